datapath: RTL and testbench

DATAPATH -- requirements
Module: Datapath

---
 rtl/datapath_if.sv | 40 ++++
 rtl/datapath.sv | 143 ++++++++++++++
 tb/tb_datapath.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_if.sv
// -----------------------------------------------------------------------------
// datapath_if
//   Bundle of the datapath control, memory-data and bus-observation signals.
//   A driver (sequencer or testbench) uses the master modport, and the
//   datapath side uses the slave modport.
//
//   Signals:
//     outp                 current internal bus value (datapath -> master)
//     PCout..LOout         bus source selects
//     MARin..LOin          register load enables
//     IncPC, Read          ALU increment, MDR source select
//     R5in, R2in, R4in     GPR load enables
//     Mdatain              memory read data
//     ADD..NOT             ALU op selects
// -----------------------------------------------------------------------------
interface datapath_if;
  logic [31:0] outp;
  logic        PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic        IncPC, Read;
  logic        R5in, R2in, R4in;
  logic [31:0] Mdatain;
  logic        ADD, SUB, MUL, DIV, AND, OR, SHR, SHL, ROTR, ROTL, NEG, NOT;

  modport master (
    input  outp,
    output PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
    output IncPC, Read, R5in, R2in, R4in, Mdatain,
    output ADD, SUB, MUL, DIV, AND, OR, SHR, SHL, ROTR, ROTL, NEG, NOT
  );

  modport slave (
    output outp,
    input  PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
    input  IncPC, Read, R5in, R2in, R4in, Mdatain,
    input  ADD, SUB, MUL, DIV, AND, OR, SHR, SHL, ROTR, ROTL, NEG, NOT
  );
endinterface

// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
//   Single-bus CPU datapath: registers R2, R4, R5, PC, IR, Y, MAR, MDR, HI, LO
//   (32 bit) and Z (64 bit), a priority bus mux and an ALU with A = Y, B = bus.
//
//   Ports (positional order is fixed):
//     outp              out 32  current bus value (combinational)
//     PCout..LOout      in  1   bus source selects, PCout highest priority
//     MARin..LOin       in  1   register load enables (Zin loads ALU result)
//     IncPC             in  1   ALU result = bus + 1 (highest op priority)
//     Read              in  1   MDR source: 1 = Mdatain, 0 = bus
//     R5in, R2in, R4in  in  1   GPR load enables
//     Clock             in  1   rising-edge clock
//     Clear             in  1   asynchronous active-high reset
//     Mdatain           in  32  memory read data
//     ADD..NOT          in  1   ALU op selects, ADD highest after IncPC
//
//   Configuration macro: DATAPATH_MULDIV_EN
//     defined   -> MUL (signed 64-bit product) and DIV (signed quotient in
//                  Zlo, remainder in Zhi) are implemented.
//     undefined -> MUL/DIV selects are ignored and fall through the priority.
// -----------------------------------------------------------------------------
module datapath (
  output logic [31:0] outp,
  input  logic        PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout,
  input  logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        R5in, R2in, R4in,
  input  logic        Clock, Clear,
  input  logic [31:0] Mdatain,
  input  logic        ADD, SUB, MUL, DIV, AND, OR, SHR, SHL, ROTR, ROTL, NEG, NOT
);

  logic [31:0] r2_q, r4_q, r5_q, pc_q, ir_q, y_q, mar_q, mdr_q, hi_q, lo_q;
  logic [31:0] r2_d, r4_d, r5_d, pc_d, ir_d, y_d, mar_d, mdr_d, hi_d, lo_d;
  logic [63:0] z_q, z_d;

  logic [31:0] bus;
  logic [63:0] alu_res;
  logic [4:0]  sh_amt;
  logic [63:0] rot_r, rot_l;

  // Bus priority mux; idle bus reads as zero.
  always_comb begin
    bus = 32'd0;
    if      (PCout)   bus = pc_q;
    else if (Zhiout)  bus = z_q[63:32];
    else if (Zlowout) bus = z_q[31:0];
    else if (MDRout)  bus = mdr_q;
    else if (R2out)   bus = r2_q;
    else if (R4out)   bus = r4_q;
    else if (HIout)   bus = hi_q;
    else if (LOout)   bus = lo_q;
  end

  assign outp = bus;

  // Rotates use a doubled copy of A so a zero shift amount needs no special case.
  assign sh_amt = bus[4:0];
  assign rot_r  = {y_q, y_q} >> sh_amt;
  assign rot_l  = {y_q, y_q} << sh_amt;

`ifdef DATAPATH_MULDIV_EN
  logic [63:0]        prod;
  logic signed [31:0] quo, rem;

  // Operands sign-extended to 64 bits so the full signed product is kept.
  assign prod = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
  assign quo  = $signed(y_q) / $signed(bus);
  assign rem  = $signed(y_q) % $signed(bus);
`endif

  // ALU with fixed op priority; with no op selected Z receives the bus value.
  always_comb begin
    alu_res = {32'd0, bus};
    if      (IncPC) alu_res = {32'd0, bus + 32'd1};
    else if (ADD)   alu_res = {32'd0, y_q + bus};
    else if (SUB)   alu_res = {32'd0, y_q - bus};
`ifdef DATAPATH_MULDIV_EN
    else if (MUL)   alu_res = prod;
    else if (DIV)   alu_res = (bus == 32'd0) ? {y_q, 32'hFFFF_FFFF} : {rem, quo};
`endif
    else if (AND)   alu_res = {32'd0, y_q & bus};
    else if (OR)    alu_res = {32'd0, y_q | bus};
    else if (SHR)   alu_res = {32'd0, y_q >> sh_amt};
    else if (SHL)   alu_res = {32'd0, y_q << sh_amt};
    else if (ROTR)  alu_res = {32'd0, rot_r[31:0]};
    else if (ROTL)  alu_res = {32'd0, rot_l[63:32]};
    else if (NEG)   alu_res = {32'd0, 32'd0 - bus};
    else if (NOT)   alu_res = {32'd0, ~bus};
  end

  // Next-state: each register holds unless its enable is high.
  always_comb begin
    r2_d  = R2in  ? bus : r2_q;
    r4_d  = R4in  ? bus : r4_q;
    r5_d  = R5in  ? bus : r5_q;
    pc_d  = PCin  ? bus : pc_q;
    ir_d  = IRin  ? bus : ir_q;
    y_d   = Yin   ? bus : y_q;
    mar_d = MARin ? bus : mar_q;
    hi_d  = HIin  ? bus : hi_q;
    lo_d  = LOin  ? bus : lo_q;
    mdr_d = MDRin ? (Read ? Mdatain : bus) : mdr_q;
    z_d   = Zin   ? alu_res : z_q;
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r2_q  <= 32'd0;
      r4_q  <= 32'd0;
      r5_q  <= 32'd0;
      pc_q  <= 32'd0;
      ir_q  <= 32'd0;
      y_q   <= 32'd0;
      mar_q <= 32'd0;
      mdr_q <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      z_q   <= 64'd0;
    end else begin
      r2_q  <= r2_d;
      r4_q  <= r4_d;
      r5_q  <= r5_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      y_q   <= y_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      z_q   <= z_d;
    end
  end

  // MAR, IR and R5 have no bus driver in this slice, and MUL/DIV are unused
  // when the multiply/divide unit is left out; fold them into a sink so they
  // are not reported as dead logic.
  logic unused_sink;
  assign unused_sink = ^{MUL, DIV, mar_q, ir_q, r5_q};

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  logic Clock;
  logic Clear;

  datapath_if dif ();

  datapath dut (
    .outp    (dif.outp),
    .PCout   (dif.PCout),  .Zhiout (dif.Zhiout), .Zlowout (dif.Zlowout),
    .MDRout  (dif.MDRout), .R2out  (dif.R2out),  .R4out   (dif.R4out),
    .HIout   (dif.HIout),  .LOout  (dif.LOout),
    .MARin   (dif.MARin),  .Zin    (dif.Zin),    .PCin    (dif.PCin),
    .MDRin   (dif.MDRin),  .IRin   (dif.IRin),   .Yin     (dif.Yin),
    .HIin    (dif.HIin),   .LOin   (dif.LOin),
    .IncPC   (dif.IncPC),  .Read   (dif.Read),
    .R5in    (dif.R5in),   .R2in   (dif.R2in),   .R4in    (dif.R4in),
    .Clock   (Clock),      .Clear  (Clear),
    .Mdatain (dif.Mdatain),
    .ADD     (dif.ADD),    .SUB    (dif.SUB),    .MUL     (dif.MUL),
    .DIV     (dif.DIV),    .AND    (dif.AND),    .OR      (dif.OR),
    .SHR     (dif.SHR),    .SHL    (dif.SHL),    .ROTR    (dif.ROTR),
    .ROTL    (dif.ROTL),   .NEG    (dif.NEG),    .NOT     (dif.NOT)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // sel: [7]PC [6]Zhi [5]Zlo [4]MDR [3]R2 [2]R4 [1]HI [0]LO
  localparam logic [7:0] S_PC = 8'h80, S_ZHI = 8'h40, S_ZLO = 8'h20, S_MDR = 8'h10;
  localparam logic [7:0] S_R2 = 8'h08, S_R4 = 8'h04, S_HI = 8'h02, S_LO = 8'h01;
  // en: [7]MAR [6]Z [5]PC [4]MDR [3]IR [2]Y [1]HI [0]LO
  localparam logic [7:0] E_MAR = 8'h80, E_Z = 8'h40, E_PC = 8'h20, E_MDR = 8'h10;
  localparam logic [7:0] E_IR = 8'h08, E_Y = 8'h04, E_HI = 8'h02, E_LO = 8'h01;
  // gpr: [2]R5 [1]R2 [0]R4
  localparam logic [2:0] G_R5 = 3'b100, G_R2 = 3'b010, G_R4 = 3'b001;
  localparam logic [11:0] O_ADD = 12'h800, O_SUB = 12'h400, O_MUL = 12'h200, O_DIV = 12'h100;
  localparam logic [11:0] O_AND = 12'h080, O_OR = 12'h040, O_SHR = 12'h020, O_SHL = 12'h010;
  localparam logic [11:0] O_ROTR = 12'h008, O_ROTL = 12'h004, O_NEG = 12'h002, O_NOT = 12'h001;

`ifdef DATAPATH_MULDIV_EN
  localparam logic [31:0] X_MUL_SM = 32'd36, X_MUL_AND = 32'd36, X_DIV_SM = 32'd4;
  localparam logic [31:0] X_MUL_HI = 32'hFFFF_FFFF, X_MUL_LO = 32'hFFFF_FFF1;
  localparam logic [31:0] X_DZ_LO = 32'hFFFF_FFFF, X_DZ_HI = 32'd7;
  localparam logic [31:0] X_SD_LO = 32'hFFFF_FFFD, X_SD_HI = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] X_MUL_SM = 32'd3, X_MUL_AND = 32'd0, X_DIV_SM = 32'd3;
  localparam logic [31:0] X_MUL_HI = 32'd0, X_MUL_LO = 32'd5;
  localparam logic [31:0] X_DZ_LO = 32'd0, X_DZ_HI = 32'd0;
  localparam logic [31:0] X_SD_LO = 32'd2, X_SD_HI = 32'd0;
`endif

  typedef struct {
    logic [7:0]  sel;
    logic [7:0]  en;
    logic [2:0]  gpr;
    logic        inc;
    logic        rd;
    logic [11:0] op;
    logic [31:0] md;
    logic [31:0] exp;   // expected outp while this vector is applied
  } vec_t;

  vec_t tbl[$];
  int checks;
  int failures;

  function automatic vec_t mk(input logic [7:0] sel, input logic [7:0] en,
                              input logic [2:0] gpr, input logic inc, input logic rd,
                              input logic [11:0] op, input logic [31:0] md,
                              input logic [31:0] exp);
    vec_t v;
    v.sel = sel; v.en = en; v.gpr = gpr; v.inc = inc; v.rd = rd;
    v.op = op; v.md = md; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    {dif.PCout, dif.Zhiout, dif.Zlowout, dif.MDRout,
     dif.R2out, dif.R4out, dif.HIout, dif.LOout} = v.sel;
    {dif.MARin, dif.Zin, dif.PCin, dif.MDRin,
     dif.IRin, dif.Yin, dif.HIin, dif.LOin} = v.en;
    {dif.R5in, dif.R2in, dif.R4in} = v.gpr;
    dif.IncPC   = v.inc;
    dif.Read    = v.rd;
    {dif.ADD, dif.SUB, dif.MUL, dif.DIV, dif.AND, dif.OR,
     dif.SHR, dif.SHL, dif.ROTR, dif.ROTL, dif.NEG, dif.NOT} = v.op;
    dif.Mdatain = v.md;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Helpers for the ALU pairs: op into Z with R4 (=3) on the bus, then read Zlo.
  task automatic alu_pair(input logic inc, input logic [11:0] op, input logic [31:0] res);
    tbl.push_back(mk(S_R4, E_Z, '0, inc, 1'b0, op, '0, 32'd3));
    tbl.push_back(mk(S_ZLO, '0, '0, 1'b0, 1'b0, '0, '0, res));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    Clear    = 1'b1;
    drive(mk('0, '0, '0, 1'b0, 1'b0, '0, '0, '0));

    // ---------------- vector table ----------------
    tbl.push_back(mk(8'hFF, '0, '0, 1'b0, 1'b0, '0, '0, 32'd0));              // reset: all zero
    tbl.push_back(mk('0, E_MDR, '0, 1'b0, 1'b1, '0, 32'd12, 32'd0));           // MDR<=12
    tbl.push_back(mk(S_MDR, '0, G_R2, 1'b0, 1'b0, '0, '0, 32'd12));            // R2<=12
    tbl.push_back(mk('0, E_MDR, '0, 1'b0, 1'b1, '0, 32'd3, 32'd0));            // MDR<=3
    tbl.push_back(mk(S_MDR, '0, G_R4, 1'b0, 1'b0, '0, '0, 32'd3));             // R4<=3
    tbl.push_back(mk(S_R2, E_Y, '0, 1'b0, 1'b0, '0, '0, 32'd12));              // Y<=12
    tbl.push_back(mk(S_R4, E_Z, '0, 1'b0, 1'b0, O_ROTR, '0, 32'd3));           // Z<=rotr(12,3)
    tbl.push_back(mk(S_ZLO, '0, G_R5, 1'b0, 1'b0, '0, '0, 32'h8000_0001));     // R5<=Zlo
    tbl.push_back(mk(S_ZHI, '0, '0, 1'b0, 1'b0, '0, '0, 32'd0));
    tbl.push_back(mk(S_R4, E_MDR, '0, 1'b0, 1'b0, '0, 32'hDEAD_BEEF, 32'd3));  // Read=0: MDR<=bus
    tbl.push_back(mk(S_MDR, '0, '0, 1'b0, 1'b0, '0, '0, 32'd3));
    tbl.push_back(mk(S_R2, E_HI, '0, 1'b0, 1'b0, '0, '0, 32'd12));
    tbl.push_back(mk(S_R4, E_LO, '0, 1'b0, 1'b0, '0, '0, 32'd3));
    tbl.push_back(mk(S_HI | S_LO, '0, '0, 1'b0, 1'b0, '0, '0, 32'd12));
    tbl.push_back(mk(S_LO, '0, '0, 1'b0, 1'b0, '0, '0, 32'd3));
    tbl.push_back(mk(S_R2 | S_R4 | S_HI, '0, '0, 1'b0, 1'b0, '0, '0, 32'd12));
    tbl.push_back(mk(S_R4 | S_HI, '0, '0, 1'b0, 1'b0, '0, '0, 32'd3));
    tbl.push_back(mk(S_MDR | S_R2, '0, '0, 1'b0, 1'b0, '0, '0, 32'd3));
    tbl.push_back(mk(S_PC | S_R2, '0, '0, 1'b0, 1'b0, '0, '0, 32'd0));
    tbl.push_back(mk(S_R2, '0, G_R2, 1'b0, 1'b0, '0, '0, 32'd12));            // bus-to-self
    tbl.push_back(mk(S_R2, '0, '0, 1'b0, 1'b0, '0, '0, 32'd12));
    // ALU ops, A = Y = 12, B = 3
    alu_pair(1'b0, O_ADD, 32'd15);
    tbl.push_back(mk(S_ZHI, '0, '0, 1'b0, 1'b0, '0, '0, 32'd0));
    alu_pair(1'b0, O_SUB, 32'd9);
    alu_pair(1'b0, O_AND, 32'd0);
    alu_pair(1'b0, O_OR, 32'd15);
    alu_pair(1'b0, O_SHR, 32'd1);
    alu_pair(1'b0, O_SHL, 32'h60);
    alu_pair(1'b0, O_ROTL, 32'h60);
    alu_pair(1'b0, O_NEG, 32'hFFFF_FFFD);
    tbl.push_back(mk(S_ZHI, '0, '0, 1'b0, 1'b0, '0, '0, 32'd0));
    alu_pair(1'b0, O_NOT, 32'hFFFF_FFFC);
    alu_pair(1'b1, O_ADD, 32'd4);                   // IncPC beats ADD
    alu_pair(1'b0, O_ADD | O_SUB, 32'd15);
    alu_pair(1'b0, O_SUB | O_AND, 32'd9);
    alu_pair(1'b0, O_SHR | O_SHL, 32'd1);
    alu_pair(1'b0, O_ROTR | O_ROTL, 32'h8000_0001);
    alu_pair(1'b0, O_NEG | O_NOT, 32'hFFFF_FFFD);
    alu_pair(1'b0, '0, 32'd3);                      // no op: pass-through
    alu_pair(1'b0, O_MUL, X_MUL_SM);
    alu_pair(1'b0, O_MUL | O_AND, X_MUL_AND);
    alu_pair(1'b0, O_DIV, X_DIV_SM);
    tbl.push_back(mk(S_ZHI, '0, '0, 1'b0, 1'b0, '0, '0, 32'd0));
    // Y = -3, B = 5
    tbl.push_back(mk('0, E_MDR, '0, 1'b0, 1'b1, '0, 32'hFFFF_FFFD, 32'd0));
    tbl.push_back(mk(S_MDR, E_Y, '0, 1'b0, 1'b0, '0, '0, 32'hFFFF_FFFD));
    tbl.push_back(mk('0, E_MDR, '0, 1'b0, 1'b1, '0, 32'd5, 32'd0));
    tbl.push_back(mk(S_MDR, E_Z, '0, 1'b0, 1'b0, O_MUL, '0, 32'd5));
    tbl.push_back(mk(S_ZHI, '0, '0, 1'b0, 1'b0, '0, '0, X_MUL_HI));
    tbl.push_back(mk(S_ZLO, '0, '0, 1'b0, 1'b0, '0, '0, X_MUL_LO));
    tbl.push_back(mk(S_MDR, E_Z, '0, 1'b0, 1'b0, O_SUB, '0, 32'd5));
    tbl.push_back(mk(S_ZLO, '0, '0, 1'b0, 1'b0, '0, '0, 32'hFFFF_FFF8));
    tbl.push_back(mk(S_MDR, E_Z, '0, 1'b0, 1'b0, O_ADD, '0, 32'd5));
    tbl.push_back(mk(S_ZLO, '0, '0, 1'b0, 1'b0, '0, '0, 32'd2));      // wraps mod 2^32
    tbl.push_back(mk(S_ZHI, '0, '0, 1'b0, 1'b0, '0, '0, 32'd0));
    // Y = 7, bus idle (0): divide by zero
    tbl.push_back(mk('0, E_MDR, '0, 1'b0, 1'b1, '0, 32'd7, 32'd0));
    tbl.push_back(mk(S_MDR, E_Y, '0, 1'b0, 1'b0, '0, '0, 32'd7));
    tbl.push_back(mk('0, E_Z, '0, 1'b0, 1'b0, O_DIV, '0, 32'd0));
    tbl.push_back(mk(S_ZLO, '0, '0, 1'b0, 1'b0, '0, '0, X_DZ_LO));
    tbl.push_back(mk(S_ZHI, '0, '0, 1'b0, 1'b0, '0, '0, X_DZ_HI));
    // Y = -7, B = 2: truncation toward zero, negative remainder
    tbl.push_back(mk('0, E_MDR, '0, 1'b0, 1'b1, '0, 32'hFFFF_FFF9, 32'd0));
    tbl.push_back(mk(S_MDR, E_Y, '0, 1'b0, 1'b0, '0, '0, 32'hFFFF_FFF9));
    tbl.push_back(mk('0, E_MDR, '0, 1'b0, 1'b1, '0, 32'd2, 32'd0));
    tbl.push_back(mk(S_MDR, E_Z, '0, 1'b0, 1'b0, O_DIV, '0, 32'd2));
    tbl.push_back(mk(S_ZLO, '0, '0, 1'b0, 1'b0, '0, '0, X_SD_LO));
    tbl.push_back(mk(S_ZHI, '0, '0, 1'b0, 1'b0, '0, '0, X_SD_HI));
    tbl.push_back(mk(S_MDR, E_Z, '0, 1'b0, 1'b0, O_SHR, '0, 32'd2));  // logical shift
    tbl.push_back(mk(S_ZLO, '0, '0, 1'b0, 1'b0, '0, '0, 32'h3FFF_FFFE));

    repeat (2) @(negedge Clock);
    Clear = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge Clock);
      drive(tbl[i]);
      #1;
      check($sformatf("vec%0d", i), dif.outp, tbl[i].exp);
    end

    // ---------------- Clear between edges ----------------
    check("r5_before_clear", dut.r5_q, 32'h8000_0001);
    @(negedge Clock);
    drive(mk(S_ZLO, '0, '0, 1'b0, 1'b0, '0, '0, '0));
    #1 check("zlo_before_clear", dif.outp, 32'h3FFF_FFFE);
    #1 Clear = 1'b1;
    #1;
    check("r5_async_clear", dut.r5_q, 32'd0);
    check("zlo_async_clear", dif.outp, 32'd0);
    check("zhi_async_clear", dut.z_q[63:32], 32'd0);
    #1 Clear = 1'b0;

    // ---------------- Clear held across a load edge ----------------
    @(negedge Clock);
    drive(mk('0, E_MDR, '0, 1'b0, 1'b1, '0, 32'h55, '0));
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
    drive(mk(S_MDR, '0, '0, 1'b0, 1'b0, '0, '0, '0));
    #1 check("mdr_clear_wins", dif.outp, 32'd0);
    @(negedge Clock);
    drive(mk('0, E_MDR, '0, 1'b0, 1'b1, '0, 32'h55, '0));
    @(negedge Clock);
    drive(mk(S_MDR, '0, '0, 1'b0, 1'b0, '0, '0, '0));
    #1 check("mdr_resume", dif.outp, 32'h55);

    // ---------------- PC increment and instruction fetch ----------------
    @(negedge Clock);
    drive(mk(S_PC, E_MAR | E_Z, '0, 1'b1, 1'b0, '0, '0, '0));
    #1 check("fetch_pc0", dif.outp, 32'd0);
    @(negedge Clock);
    drive(mk(S_ZLO, E_PC, '0, 1'b0, 1'b0, '0, '0, '0));
    #1 check("fetch_zlo_inc", dif.outp, 32'd1);
    check("fetch_mar0", dut.mar_q, 32'd0);
    @(negedge Clock);
    drive(mk(S_PC, E_MAR, '0, 1'b0, 1'b0, '0, '0, '0));
    #1 check("fetch_pc1", dif.outp, 32'd1);
    @(negedge Clock);
    drive(mk('0, E_MDR, '0, 1'b0, 1'b1, '0, 32'h1A92_0000, '0));
    #1 check("fetch_mar1", dut.mar_q, 32'd1);
    @(negedge Clock);
    drive(mk(S_MDR, E_IR, '0, 1'b0, 1'b0, '0, '0, '0));
    #1 check("fetch_mdr", dif.outp, 32'h1A92_0000);
    @(negedge Clock);
    drive(mk('0, '0, '0, 1'b0, 1'b0, '0, '0, '0));
    #1 check("fetch_ir", dut.ir_q, 32'h1A92_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
